// File: rtl/wf68k30l_divider_mc.sv
// Multi-cycle signed/unsigned integer divider for the WF68K30L ALU: W/W, 2W/W and W/(W/2) forms,
// RADIX_BITS quotient bits retired per CALC cycle, operands captured at START.
module wf68k30l_divider_mc #(
  parameter int W          = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic         ABORT,
  input  logic         SIGNED_OP,
  input  logic         WIDE,
  input  logic         HALF,
  input  logic [W-1:0] DIVIDEND_LO,
  input  logic [W-1:0] DIVIDEND_HI,
  input  logic [W-1:0] DIVISOR,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] QUOTIENT,
  output logic [W-1:0] REMAINDER,
  output logic         DIV_ZERO,
  output logic         OVERFLOW,
  output logic [1:0]   STATE_DBG
);

  // Handshake: START is taken only in IDLE while DONE and ABORT are low; BUSY is high from the
  // cycle after acceptance through the one-cycle DONE pulse; ABORT returns to IDLE on the next
  // edge with no DONE and leaves results/flags untouched.

  localparam int HW       = W / 2;
  localparam int CNT_W    = $clog2(W / RADIX_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(W / RADIX_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HW / RADIX_BITS);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_INIT = 2'd1, S_CALC = 2'd2, S_FIX = 2'd3} state_t;

  state_t state, state_nx;

  logic           done_r, div_zero_r, overflow_r;
  logic [W-1:0]   quotient_r, remainder_r;
  logic           op_signed, op_wide, op_half;
  logic [W-1:0]   op_lo, op_hi, op_dvs;
  logic [W-1:0]   rem_r, q_r;
  logic [W:0]     dvs_mag_r;
  logic [CNT_W-1:0] cnt_r;
  logic           neg_q_r, neg_r_r;

  logic [2*W-1:0] dvd_full;
  logic [2*W:0]   dvd_mag, dvd_hi_part;
  logic [W-1:0]   dvs_full;
  logic [W:0]     dvs_mag;
  logic           dvd_neg, dvs_neg;
  logic           is_zero, is_ovf, is_lt, is_eq, init_term;

  logic [W-1:0]   r_step, q_step;
  logic [W:0]     t_step;
  logic           q_bit;

  logic [W-1:0]   lim, q_res, r_res;
  logic           fix_ovf;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (START && !ABORT && !done_r) state_nx = S_INIT;
      S_INIT: if (ABORT || init_term) state_nx = S_IDLE;
              else                    state_nx = S_CALC;
      S_CALC: if (ABORT)                       state_nx = S_IDLE;
              else if (cnt_r == CNT_W'(1))     state_nx = S_FIX;
      S_FIX:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY      = (state != S_IDLE) || done_r;
    DONE      = done_r;
    QUOTIENT  = quotient_r;
    REMAINDER = remainder_r;
    DIV_ZERO  = div_zero_r;
    OVERFLOW  = overflow_r;
    STATE_DBG = state;
  end

  // Magnitudes carry one spare bit so the most negative operand and the compares never wrap.
  always_comb begin
    if (!op_half && op_wide) dvd_full = {op_hi, op_lo};
    else if (op_signed)      dvd_full = {{W{op_lo[W-1]}}, op_lo};
    else                     dvd_full = {{W{1'b0}}, op_lo};
    dvd_neg = op_signed & dvd_full[2*W-1];
    dvd_mag = dvd_neg ? ({1'b0, ~dvd_full} + (2*W+1)'(1)) : {1'b0, dvd_full};

    if (!op_half)       dvs_full = op_dvs;
    else if (op_signed) dvs_full = {{HW{op_dvs[HW-1]}}, op_dvs[HW-1:0]};
    else                dvs_full = {{HW{1'b0}}, op_dvs[HW-1:0]};
    dvs_neg = op_signed & dvs_full[W-1];
    dvs_mag = dvs_neg ? ({1'b0, ~dvs_full} + (W+1)'(1)) : {1'b0, dvs_full};

    dvd_hi_part = op_half ? (dvd_mag >> HW) : (dvd_mag >> W);
    is_zero     = (dvs_mag == '0);
    is_ovf      = (dvd_hi_part >= {{W{1'b0}}, dvs_mag});
    is_lt       = ({{W{1'b0}}, dvs_mag} > dvd_mag);
    is_eq       = ({{W{1'b0}}, dvs_mag} == dvd_mag);
    init_term   = is_zero || is_ovf || is_lt || is_eq;
  end

  // Restoring division, MSB first; the dividend bits stream out of the top of q_r.
  always_comb begin
    r_step = rem_r;
    q_step = q_r;
    t_step = '0;
    q_bit  = 1'b0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      t_step = {r_step, q_step[W-1]};
      if (t_step >= dvs_mag_r) begin
        t_step = t_step - dvs_mag_r;
        q_bit  = 1'b1;
      end else begin
        q_bit  = 1'b0;
      end
      r_step = t_step[W-1:0];
      q_step = {q_step[W-2:0], q_bit};
    end
  end

  always_comb begin
    lim     = op_half ? {{HW{1'b0}}, 1'b1, {(HW-1){1'b0}}} : {1'b1, {(W-1){1'b0}}};
    fix_ovf = op_signed && (neg_q_r ? (q_r > lim) : (q_r >= lim));
    q_res   = neg_q_r ? (~q_r + W'(1)) : q_r;
    r_res   = neg_r_r ? (~rem_r + W'(1)) : rem_r;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      done_r      <= 1'b0;
      div_zero_r  <= 1'b0;
      overflow_r  <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      op_signed   <= 1'b0;
      op_wide     <= 1'b0;
      op_half     <= 1'b0;
      op_lo       <= '0;
      op_hi       <= '0;
      op_dvs      <= '0;
      rem_r       <= '0;
      q_r         <= '0;
      dvs_mag_r   <= '0;
      cnt_r       <= '0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (START && !ABORT && !done_r) begin
            op_signed <= SIGNED_OP;
            op_wide   <= WIDE;
            op_half   <= HALF;
            op_lo     <= DIVIDEND_LO;
            op_hi     <= DIVIDEND_HI;
            op_dvs    <= DIVISOR;
          end
        end
        S_INIT: begin
          if (!ABORT) begin
            if (init_term) begin
              done_r     <= 1'b1;
              div_zero_r <= is_zero;
              overflow_r <= !is_zero && is_ovf;
              if (is_zero || is_ovf) begin
                quotient_r  <= op_lo;
                remainder_r <= op_hi;
              end else if (is_lt) begin
                quotient_r  <= '0;
                remainder_r <= dvd_neg ? (~dvd_mag[W-1:0] + W'(1)) : dvd_mag[W-1:0];
              end else begin
                quotient_r  <= (dvd_neg ^ dvs_neg) ? '1 : W'(1);
                remainder_r <= '0;
              end
            end else begin
              rem_r     <= dvd_hi_part[W-1:0];
              q_r       <= op_half ? {dvd_mag[HW-1:0], {HW{1'b0}}} : dvd_mag[W-1:0];
              dvs_mag_r <= dvs_mag;
              cnt_r     <= op_half ? CNT_HALF : CNT_FULL;
              neg_q_r   <= dvd_neg ^ dvs_neg;
              neg_r_r   <= dvd_neg;
            end
          end
        end
        S_CALC: begin
          if (!ABORT) begin
            rem_r <= r_step;
            q_r   <= q_step;
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        S_FIX: begin
          if (!ABORT) begin
            done_r      <= 1'b1;
            div_zero_r  <= 1'b0;
            overflow_r  <= fix_ovf;
            quotient_r  <= fix_ovf ? op_lo : q_res;
            remainder_r <= fix_ovf ? op_hi : r_res;
          end
        end
      endcase
    end
  end

endmodule
